// File: rtl/rv32i_types_pkg.sv
// Scalar RV32I types shared with the LSC interface.
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

endpackage

// File: rtl/rv32v_types_pkg.sv
// Vector memory sequencer types: FSM states and element width.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } mem_seq_state_t;

    typedef enum logic [1:0] {
        SEW_E8  = 2'b00,
        SEW_E16 = 2'b01,
        SEW_E32 = 2'b10,
        SEW_RSV = 2'b11
    } sew_t;

    // The reserved encoding behaves as e32.
    function automatic sew_t norm_sew(input logic [1:0] s);
        return (s == 2'b11) ? SEW_E32 : sew_t'(s);
    endfunction

endpackage

// File: rtl/rv32v_mem_addr_gen.sv
// Element address accumulator, SEW alignment check and register/element split.
module rv32v_mem_addr_gen
    import rv32v_types_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int VLW  = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           i_load,
    input  logic           i_advance,
    input  logic [31:0]    i_base,
    input  logic [31:0]    i_stride,
    input  logic           i_strided,
    input  logic [1:0]     i_sew,
    input  logic [4:0]     i_vd,
    output logic [31:0]    o_addr,
    output logic [VLW-1:0] o_idx,
    output logic           o_misaligned,
    output sew_t           o_sew,
    output logic [4:0]     o_vreg,
    output logic [VLW-1:0] o_eidx
);

    localparam int EPR_LOG2_E8 = $clog2(VLEN / 8);

    logic [31:0]    r_addr;
    logic [31:0]    r_stride;
    logic           r_strided;
    sew_t           r_sew;
    logic [4:0]     r_vd;
    logic [VLW-1:0] r_idx;

    logic [31:0]    w_step;
    logic [2:0]     w_shift;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr    <= '0;
            r_stride  <= '0;
            r_strided <= 1'b0;
            r_sew     <= SEW_E32;
            r_vd      <= '0;
            r_idx     <= '0;
        end else if (i_load) begin
            r_addr    <= i_base;
            r_stride  <= i_stride;
            r_strided <= i_strided;
            r_sew     <= norm_sew(i_sew);
            r_vd      <= i_vd;
            r_idx     <= '0;
        end else if (i_advance) begin
            r_addr    <= r_addr + w_step;
            r_idx     <= r_idx + VLW'(1);
        end
    end

    assign w_step  = r_strided ? r_stride : (32'd1 << r_sew);
    // Elements per register is VLEN/(8<<sew), so the split is a shift and a mask.
    assign w_shift = 3'(EPR_LOG2_E8) - 3'(r_sew);

    always_comb begin
        o_misaligned = 1'b0;
        unique case (r_sew)
            SEW_E8:  o_misaligned = 1'b0;
            SEW_E16: o_misaligned = r_addr[0];
            default: o_misaligned = |r_addr[1:0];
        endcase
    end

    assign o_addr = r_addr;
    assign o_idx  = r_idx;
    assign o_sew  = r_sew;
    assign o_vreg = r_vd + 5'(r_idx >> w_shift);
    assign o_eidx = r_idx & ((VLW'(1) << w_shift) - VLW'(1));

endmodule

// File: rtl/rv32v_mem_sequencer.sv
// Vector load/store sequencer: splits one vector memory instruction into
// per-element LSC accesses and moves element data to/from the VRF.
module rv32v_mem_sequencer
    import rv32i_types_pkg::*;
    import rv32v_types_pkg::*;
#(
    parameter  int VLEN     = 128,
    parameter  int MAX_LMUL = 8,
    localparam int VLMAX    = VLEN * MAX_LMUL / 8,
    localparam int VLW      = $clog2(VLMAX) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             is_store,
    input  logic             strided,
    input  logic [1:0]       sew,
    input  logic [VLW-1:0]   vl,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      stride,
    input  logic [4:0]       vd,
    input  logic             mask_en,
    input  logic [VLMAX-1:0] vmask,
    input  logic [31:0]      vrf_rdata,
    input  logic [31:0]      dload_ext,
    input  logic             lsc_stall,
    input  logic             fence_stall,
    output logic             wen,
    output logic             ren,
    output logic [31:0]      addr,
    output logic [31:0]      store_data,
    output load_t            load_type,
    output logic             ifence,
    output logic             vrf_wen,
    output logic [4:0]       vrf_vreg,
    output logic [VLW-1:0]   vrf_eidx,
    output logic [31:0]      vrf_wdata,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [VLW-1:0]   fault_idx
);

    localparam int IW = $clog2(VLMAX);

    mem_seq_state_t   r_state, w_next;
    logic             r_is_store;
    logic             r_mask_en;
    logic [VLW-1:0]   r_vl;
    logic [VLMAX-1:0] r_vmask;
    logic [VLW-1:0]   r_fault_idx;

    logic [31:0]      w_addr;
    logic [VLW-1:0]   w_idx;
    logic             w_misaligned;
    sew_t             w_sew;
    logic             w_accept, w_access, w_skip, w_req, w_complete;
    logic             w_advance, w_last, w_fault_hit;

    rv32v_mem_addr_gen #(.VLEN(VLEN), .VLW(VLW)) u_addr_gen (
        .CLK         (CLK),
        .RST         (RST),
        .i_load      (w_accept),
        .i_advance   (w_advance),
        .i_base      (base_addr),
        .i_stride    (stride),
        .i_strided   (strided),
        .i_sew       (sew),
        .i_vd        (vd),
        .o_addr      (w_addr),
        .o_idx       (w_idx),
        .o_misaligned(w_misaligned),
        .o_sew       (w_sew),
        .o_vreg      (vrf_vreg),
        .o_eidx      (vrf_eidx)
    );

    // Priority per element: mask skip, then alignment fault, then fence hold.
    assign w_accept    = (r_state == IDLE) && start;
    assign w_access    = (r_state == ACCESS);
    assign w_skip      = r_mask_en && !r_vmask[w_idx[IW-1:0]];
    assign w_fault_hit = w_access && !w_skip && w_misaligned;
    assign w_req       = w_access && !w_skip && !w_misaligned && !fence_stall;
    assign w_complete  = w_req && !lsc_stall;
    assign w_advance   = w_access && (w_skip || w_complete);
    assign w_last      = (w_idx == r_vl - VLW'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (vl == '0) ? DONE : ACCESS;
            ACCESS:  if (w_fault_hit) w_next = FAULT;
                     else if (w_advance && w_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_is_store  <= 1'b0;
            r_mask_en   <= 1'b0;
            r_vl        <= '0;
            r_vmask     <= '0;
            r_fault_idx <= '0;
        end else if (w_accept) begin
            r_is_store  <= is_store;
            r_mask_en   <= mask_en;
            r_vl        <= vl;
            r_vmask     <= vmask;
            r_fault_idx <= '0;
        end else if (w_fault_hit) begin
            r_fault_idx <= w_idx;
        end
    end

    always_comb begin
        ren        = w_req && !r_is_store;
        wen        = w_req && r_is_store;
        addr       = w_access ? w_addr : '0;
        store_data = '0;
        load_type  = LW;
        ifence     = 1'b0;
        vrf_wen    = w_complete && !r_is_store;
        vrf_wdata  = '0;
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        fault      = (r_state == FAULT);
        fault_idx  = r_fault_idx;
        unique case (w_sew)
            SEW_E8:  load_type = LBU;
            SEW_E16: load_type = LHU;
            default: load_type = LW;
        endcase
        if (wen) begin
            unique case (w_sew)
                SEW_E8:  store_data = {24'b0, vrf_rdata[7:0]};
                SEW_E16: store_data = {16'b0, vrf_rdata[15:0]};
                default: store_data = vrf_rdata;
            endcase
        end
        if (vrf_wen) vrf_wdata = dload_ext;
    end

endmodule

// File: tb/tb_rv32v_mem_sequencer.sv
// Directed bench for rv32v_mem_sequencer with a tiny VRF/LSC data model.
module tb_rv32v_mem_sequencer;
    import rv32i_types_pkg::*;

    localparam int VLW   = 8;
    localparam int VLMAX = 128;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start, is_store, strided, mask_en, lsc_stall, fence_stall;
    logic [1:0]       sew;
    logic [VLW-1:0]   vl;
    logic [31:0]      base_addr, stride, vrf_rdata, dload_ext;
    logic [4:0]       vd;
    logic [VLMAX-1:0] vmask;
    logic             wen, ren, ifence, vrf_wen, busy, done, fault;
    logic [31:0]      addr, store_data, vrf_wdata;
    load_t            load_type;
    logic [4:0]       vrf_vreg;
    logic [VLW-1:0]   vrf_eidx, fault_idx;

    int n_vec = 0;
    int n_err = 0;

    rv32v_mem_sequencer #(.VLEN(128), .MAX_LMUL(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .is_store(is_store), .strided(strided),
        .sew(sew), .vl(vl), .base_addr(base_addr), .stride(stride), .vd(vd),
        .mask_en(mask_en), .vmask(vmask), .vrf_rdata(vrf_rdata), .dload_ext(dload_ext),
        .lsc_stall(lsc_stall), .fence_stall(fence_stall), .wen(wen), .ren(ren),
        .addr(addr), .store_data(store_data), .load_type(load_type), .ifence(ifence),
        .vrf_wen(vrf_wen), .vrf_vreg(vrf_vreg), .vrf_eidx(vrf_eidx), .vrf_wdata(vrf_wdata),
        .busy(busy), .done(done), .fault(fault), .fault_idx(fault_idx)
    );

    always #5 CLK = ~CLK;

    // Upper bits are deliberately non-zero so narrow stores must be trimmed.
    assign vrf_rdata = {16'hCAFE, vrf_vreg, 3'b000, vrf_eidx + 8'h30};
    assign dload_ext = addr + 32'h5500_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk1;
        @(posedge CLK);
        #3;
    endtask

    task automatic issue(input logic st, input logic sd, input logic [1:0] sw,
                         input logic [VLW-1:0] n, input logic [31:0] base,
                         input logic [31:0] strd, input logic [4:0] v,
                         input logic me, input logic [VLMAX-1:0] vm);
        is_store = st; strided = sd; sew = sw; vl = n; base_addr = base;
        stride = strd; vd = v; mask_en = me; vmask = vm; start = 1'b1;
        clk1;
        start = 1'b0;
        #1;
    endtask

    initial begin
        RST = 1'b1; start = 0; is_store = 0; strided = 0; mask_en = 0;
        lsc_stall = 0; fence_stall = 0; sew = 0; vl = 0; base_addr = 0;
        stride = 0; vd = 0; vmask = '0;
        #1;
        chk("rst_busy", busy, 0);   chk("rst_ren", ren, 0);     chk("rst_wen", wen, 0);
        chk("rst_done", done, 0);   chk("rst_fault", fault, 0); chk("rst_ltype", load_type, LW);
        chk("rst_fidx", fault_idx, 0); chk("rst_ifence", ifence, 0);
        #12 RST = 1'b0;
        clk1;

        // 1: e32 unit-stride load, vl=4, base 0x100, vd=2
        issue(0, 0, 2'b10, 4, 32'h100, 0, 2, 0, '0);
        chk("t1_ltype", load_type, LW);
        for (int i = 0; i < 4; i++) begin
            chk("t1_ren", ren, 1);          chk("t1_wen", wen, 0);
            chk("t1_addr", addr, 32'h100 + 4 * i);
            chk("t1_vwen", vrf_wen, 1);     chk("t1_vreg", vrf_vreg, 2);
            chk("t1_eidx", vrf_eidx, i);    chk("t1_wdata", vrf_wdata, 32'h5500_0100 + 4 * i);
            chk("t1_done_lo", done, 0);
            clk1;
        end
        chk("t1_done", done, 1); chk("t1_busy", busy, 1); chk("t1_ren_off", ren, 0);
        clk1;
        chk("t1_idle_done", done, 0); chk("t1_idle_busy", busy, 0);

        // 2: e8 strided store, stride -3, base 0x20, vl=3, vd=5
        issue(1, 1, 2'b00, 3, 32'h20, 32'hFFFF_FFFD, 5, 0, '0);
        chk("t2_ltype", load_type, LBU);
        for (int i = 0; i < 3; i++) begin
            chk("t2_wen", wen, 1);          chk("t2_ren", ren, 0);
            chk("t2_addr", addr, 32'h20 - 3 * i);
            chk("t2_sdata", store_data, 32'h30 + i);
            chk("t2_vwen", vrf_wen, 0);     chk("t2_vreg", vrf_vreg, 5);
            chk("t2_eidx", vrf_eidx, i);
            clk1;
        end
        chk("t2_done", done, 1);
        clk1;

        // 3: e16 masked load, vmask=0101, plus a start while busy
        issue(0, 0, 2'b01, 4, 32'h200, 0, 1, 1, 128'b0101);
        chk("t3_ltype", load_type, LHU);
        chk("t3_ren0", ren, 1); chk("t3_addr0", addr, 32'h200); chk("t3_vwen0", vrf_wen, 1);
        clk1;
        chk("t3_ren1", ren, 0); chk("t3_vwen1", vrf_wen, 0);
        start = 1'b1; base_addr = 32'h900; vl = 1;
        clk1;
        chk("t3_ren2", ren, 1); chk("t3_addr2", addr, 32'h204); chk("t3_vwen2", vrf_wen, 1);
        chk("t3_eidx2", vrf_eidx, 2); chk("t3_vreg2", vrf_vreg, 1);
        start = 1'b0;
        clk1;
        chk("t3_ren3", ren, 0); chk("t3_vwen3", vrf_wen, 0); chk("t3_busy3", busy, 1);
        clk1;
        chk("t3_done", done, 1);
        clk1;

        // 4: lsc_stall on idx1 for 3 cycles, then fence_stall on idx2
        issue(0, 0, 2'b10, 3, 32'h300, 0, 4, 0, '0);
        chk("t4_addr0", addr, 32'h300); chk("t4_vwen0", vrf_wen, 1);
        clk1;
        lsc_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_ren", ren, 1); chk("t4_stall_addr", addr, 32'h304);
            chk("t4_stall_vwen", vrf_wen, 0);
            clk1;
        end
        lsc_stall = 1'b0;
        #1;
        chk("t4_cmp_ren", ren, 1); chk("t4_cmp_addr", addr, 32'h304);
        chk("t4_cmp_vwen", vrf_wen, 1); chk("t4_cmp_eidx", vrf_eidx, 1);
        chk("t4_cmp_wdata", vrf_wdata, 32'h5500_0304);
        clk1;
        fence_stall = 1'b1;
        #1;
        chk("t4_fence_ren", ren, 0); chk("t4_fence_vwen", vrf_wen, 0); chk("t4_fence_busy", busy, 1);
        clk1;
        fence_stall = 1'b0;
        #1;
        chk("t4_ren2", ren, 1); chk("t4_addr2", addr, 32'h308); chk("t4_vwen2", vrf_wen, 1);
        clk1;
        chk("t4_done", done, 1);
        clk1;

        // 5a: e32 strided by 2 -> idx1 misaligned
        issue(0, 1, 2'b10, 3, 32'h400, 32'd2, 0, 0, '0);
        chk("t5a_ren0", ren, 1); chk("t5a_addr0", addr, 32'h400);
        clk1;
        chk("t5a_ren1", ren, 0); chk("t5a_vwen1", vrf_wen, 0); chk("t5a_fault_lo", fault, 0);
        clk1;
        chk("t5a_fault", fault, 1); chk("t5a_fidx", fault_idx, 1); chk("t5a_ren", ren, 0);
        chk("t5a_done", done, 0);
        clk1;
        chk("t5a_fault_end", fault, 0); chk("t5a_fidx_held", fault_idx, 1); chk("t5a_busy", busy, 0);

        // 5b: e16 load at 0x101 faults on element 0
        issue(0, 0, 2'b01, 2, 32'h101, 0, 0, 0, '0);
        chk("t5b_ren", ren, 0); chk("t5b_fault_lo", fault, 0);
        clk1;
        chk("t5b_fault", fault, 1); chk("t5b_fidx", fault_idx, 0); chk("t5b_ren_f", ren, 0);
        clk1;
        chk("t5b_fault_end", fault, 0); chk("t5b_busy", busy, 0);

        // 5c: asynchronous reset in the middle of an access
        issue(0, 0, 2'b10, 4, 32'h500, 0, 3, 0, '0);
        chk("t5c_ren0", ren, 1);
        clk1;
        chk("t5c_addr1", addr, 32'h504); chk("t5c_vreg1", vrf_vreg, 3);
        RST = 1'b1;
        #1;
        chk("t5c_ren", ren, 0);       chk("t5c_busy", busy, 0);  chk("t5c_addr", addr, 0);
        chk("t5c_vwen", vrf_wen, 0);  chk("t5c_vreg", vrf_vreg, 0); chk("t5c_eidx", vrf_eidx, 0);
        chk("t5c_ltype", load_type, LW); chk("t5c_wdata", vrf_wdata, 0);
        RST = 1'b0;
        clk1;
        chk("t5c_post_busy", busy, 0); chk("t5c_post_ren", ren, 0);

        // 6a: vl=0 finishes without any access
        issue(0, 0, 2'b10, 0, 32'h600, 0, 0, 0, '0);
        chk("t6a_done", done, 1); chk("t6a_ren", ren, 0); chk("t6a_wen", wen, 0);
        clk1;
        chk("t6a_done_end", done, 0); chk("t6a_busy", busy, 0);

        // 6b: address wraps past 2^32
        issue(0, 0, 2'b10, 2, 32'hFFFF_FFFC, 0, 6, 0, '0);
        chk("t6b_addr0", addr, 32'hFFFF_FFFC); chk("t6b_ren0", ren, 1);
        clk1;
        chk("t6b_addr1", addr, 32'h0); chk("t6b_ren1", ren, 1); chk("t6b_eidx1", vrf_eidx, 1);
        clk1;
        chk("t6b_done", done, 1);
        clk1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
